// File: rtl/rom_load_pkg.sv
// Shared types and constants for the ROM download controller.
// Region indices select a bit of the one-hot write strobe.
package rom_load_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    HOLD = 3'd2,
    RUN  = 3'd3,
    FAIL = 3'd4
  } state_e;

  localparam logic [1:0] REG_PROG = 2'd0;
  localparam logic [1:0] REG_VEC  = 2'd1;
  localparam logic [1:0] REG_PROM = 2'd2;

endpackage

// File: rtl/rom_load_ctrl_if.sv
// ioctl download stream in, region write port out.
// master = hps_io side, slave = rom_load_ctrl.
interface rom_load_ctrl_if;

  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic [2:0]  dn_wr;

  modport master (
    output ioctl_download,
    output ioctl_wr,
    output ioctl_addr,
    output ioctl_dout,
    input  dn_addr,
    input  dn_data,
    input  dn_wr
  );

  modport slave (
    input  ioctl_download,
    input  ioctl_wr,
    input  ioctl_addr,
    input  ioctl_dout,
    output dn_addr,
    output dn_data,
    output dn_wr
  );

endinterface

// File: rtl/rom_region_decode.sv
// Maps a linear download address to region strobe and offset.
// Compares happen at full address width so high bits never alias.
module rom_region_decode
  import rom_load_pkg::*;
#(
  parameter int unsigned REG0_SIZE = 'h2000,
  parameter int unsigned REG1_SIZE = 'h1000,
  parameter int unsigned REG2_SIZE = 'h0100
) (
  input  logic [24:0] addr,
  output logic [2:0]  sel,
  output logic [15:0] offset,
  output logic        ovf
);

  localparam logic [24:0] B1  = 25'(REG0_SIZE);
  localparam logic [24:0] B2  = 25'(REG0_SIZE + REG1_SIZE);
  localparam logic [24:0] TOT =
    25'(REG0_SIZE + REG1_SIZE + REG2_SIZE);

  always_comb begin
    sel    = '0;
    offset = '0;
    ovf    = 1'b0;
    if (addr < B1) begin
      sel[REG_PROG] = 1'b1;
      offset        = 16'(addr);
    end else if (addr < B2) begin
      sel[REG_VEC] = 1'b1;
      offset       = 16'(addr - B1);
    end else if (addr < TOT) begin
      sel[REG_PROM] = 1'b1;
      offset        = 16'(addr - B2);
    end else begin
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/rom_load_ctrl.sv
// ROM download sequencer: region routing, byte count/checksum,
// and core reset hold until a complete, in-range load settles.
module rom_load_ctrl
  import rom_load_pkg::*;
#(
  parameter int unsigned REG0_SIZE   = 'h2000,
  parameter int unsigned REG1_SIZE   = 'h1000,
  parameter int unsigned REG2_SIZE   = 'h0100,
  parameter int unsigned HOLD_CYCLES = 1024
) (
  input  logic        clk_25,
  input  logic        reset,
  rom_load_ctrl_if.slave io,
  output logic        core_reset,
  output logic        load_ok,
  output logic        load_err,
  output logic [16:0] byte_count,
  output logic [15:0] checksum
);

  localparam int unsigned TOTAL =
    REG0_SIZE + REG1_SIZE + REG2_SIZE;
  localparam int CW =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_e        state_q, state_d;
  logic          dl_q;
  logic [CW-1:0] hold_q, hold_d;
  logic          ovf_q, ovf_d;
  logic [16:0]   cnt_q, cnt_d;
  logic [15:0]   sum_q, sum_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;
  logic          crst_q, crst_d;
  logic [2:0]    wr_q, wr_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    data_q, data_d;

  logic [2:0]  dec_sel;
  logic [15:0] dec_off;
  logic        dec_ovf;
  logic        rise, fall, take;

  rom_region_decode #(
    .REG0_SIZE (REG0_SIZE),
    .REG1_SIZE (REG1_SIZE),
    .REG2_SIZE (REG2_SIZE)
  ) u_dec (
    .addr   (io.ioctl_addr),
    .sel    (dec_sel),
    .offset (dec_off),
    .ovf    (dec_ovf)
  );

  assign rise = io.ioctl_download & ~dl_q;
  assign fall = ~io.ioctl_download & dl_q;
  assign take = io.ioctl_wr & io.ioctl_download
              & (rise | (state_q == LOAD));

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    ok_d    = ok_q;
    err_d   = err_q;
    wr_d    = '0;
    addr_d  = addr_q;
    data_d  = data_q;
    if (rise) begin
      state_d = LOAD;
      cnt_d   = '0;
      sum_d   = '0;
      ok_d    = 1'b0;
      err_d   = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (fall) begin
            state_d = HOLD;
            hold_d  = CW'(HOLD_CYCLES - 1);
          end
        end
        HOLD: begin
          if (hold_q == '0) begin
            if (cnt_q == 17'(TOTAL) && !ovf_q) begin
              state_d = RUN;
              ok_d    = 1'b1;
            end else begin
              state_d = FAIL;
              err_d   = 1'b1;
            end
          end else begin
            hold_d = hold_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
    // Byte acceptance applies after any same-cycle clear.
    if (take) begin
      if (dec_ovf) begin
        ovf_d = 1'b1;
      end else begin
        wr_d   = dec_sel;
        addr_d = dec_off;
        data_d = io.ioctl_dout;
        if (cnt_d != '1) cnt_d = cnt_d + 17'd1;
        sum_d = sum_d + {8'd0, io.ioctl_dout};
      end
    end
    crst_d = (state_d != RUN);
  end

  // dl_q resets high so a download already in flight at
  // reset release is not mistaken for a new one.
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dl_q    <= 1'b1;
      hold_q  <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      crst_q  <= 1'b1;
      wr_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      dl_q    <= io.ioctl_download;
      hold_q  <= hold_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      crst_q  <= crst_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign io.dn_wr    = wr_q;
  assign io.dn_addr  = addr_q;
  assign io.dn_data  = data_q;
  assign core_reset  = crst_q;
  assign load_ok     = ok_q;
  assign load_err    = err_q;
  assign byte_count  = cnt_q;
  assign checksum    = sum_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Scoreboard bench for rom_load_ctrl: random loads against
// an address-arithmetic reference model.
module tb_rom_load_ctrl;

  localparam int R0    = 'h2000;
  localparam int R1    = 'h1000;
  localparam int R2    = 'h0100;
  localparam int TOTAL = R0 + R1 + R2;
  localparam int HOLD  = 1024;

  logic clk_25 = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_25 = ~clk_25;

  rom_load_ctrl_if io();

  logic        core_reset;
  logic        load_ok;
  logic        load_err;
  logic [16:0] byte_count;
  logic [15:0] checksum;

  rom_load_ctrl #(
    .REG0_SIZE   (R0),
    .REG1_SIZE   (R1),
    .REG2_SIZE   (R2),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk_25     (clk_25),
    .reset      (reset),
    .io         (io.slave),
    .core_reset (core_reset),
    .load_ok    (load_ok),
    .load_err   (load_err),
    .byte_count (byte_count),
    .checksum   (checksum)
  );

  typedef struct {
    logic [2:0]  wr;
    logic [15:0] addr;
    logic [7:0]  data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int tot_r[3] = '{0, 0, 0};
  int base_r[3];

  int m_cnt;
  int m_sum;
  bit m_ovf;
  bit m_live;

  always @(posedge clk_25) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic void ref_decode(input int a,
                                     output logic [2:0] w,
                                     output int off);
    if (a < R0) begin
      w = 3'b001; off = a;
    end else if (a < R0 + R1) begin
      w = 3'b010; off = a - R0;
    end else begin
      w = 3'b100; off = a - R0 - R1;
    end
  endfunction

  task automatic send_byte(input int a, input logic [7:0] d);
    logic [2:0] w;
    int off;
    io.ioctl_wr   = 1'b1;
    io.ioctl_addr = 25'(a);
    io.ioctl_dout = d;
    if (m_live && io.ioctl_download) begin
      if (a < TOTAL) begin
        ref_decode(a, w, off);
        q.push_back('{w, 16'(off), d, cyc + 1});
        m_cnt++;
        m_sum = (m_sum + int'(d)) % 65536;
      end else begin
        m_ovf = 1'b1;
      end
    end
    @(negedge clk_25);
    io.ioctl_wr = 1'b0;
  endtask

  task automatic start_dl();
    io.ioctl_download = 1'b1;
    m_live = 1'b1;
    m_cnt  = 0;
    m_sum  = 0;
    m_ovf  = 1'b0;
    for (int k = 0; k < 3; k++) base_r[k] = tot_r[k];
  endtask

  task automatic finish_dl(input bit wr_on_fall);
    bit exp_run;
    bit early;
    int n;
    exp_run = (m_cnt == TOTAL) && !m_ovf;
    early = 1'b0;
    n = 0;
    io.ioctl_download = 1'b0;
    if (wr_on_fall) begin
      io.ioctl_wr   = 1'b1;
      io.ioctl_addr = 25'd5;
    end
    m_live = 1'b0;
    for (int i = 1; i <= HOLD + 80; i++) begin
      @(negedge clk_25);
      io.ioctl_wr = 1'b0;
      n = i;
      if (load_ok || load_err) break;
      if (!core_reset) early = 1'b1;
    end
    chk("hold_len", n, HOLD + 1);
    chk("early_release", 32'(early), 0);
    chk("core_reset", 32'(core_reset), 32'(!exp_run));
    chk("load_ok", 32'(load_ok), 32'(exp_run));
    chk("load_err", 32'(load_err), 32'(!exp_run));
    chk("byte_count", 32'(byte_count), m_cnt);
    chk("checksum", 32'(checksum), m_sum);
    chk("strobes_pending", q.size(), 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_dn_wr", 32'(io.dn_wr), 0);
    chk("rst_dn_addr", 32'(io.dn_addr), 0);
    chk("rst_dn_data", 32'(io.dn_data), 0);
    chk("rst_core_reset", 32'(core_reset), 1);
    chk("rst_load_ok", 32'(load_ok), 0);
    chk("rst_load_err", 32'(load_err), 0);
    chk("rst_byte_count", 32'(byte_count), 0);
    chk("rst_checksum", 32'(checksum), 0);
  endtask

  task automatic full_load(input bit rnd);
    for (int a = 0; a < TOTAL; a++) begin
      if (rnd && $urandom_range(0, 7) == 0)
        @(negedge clk_25);
      send_byte(a, rnd ? 8'($urandom) : 8'(a));
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk_25);
      if (io.dn_wr !== 3'b000) begin
        for (int k = 0; k < 3; k++)
          if (io.dn_wr[k] === 1'b1) tot_r[k]++;
        if (q.size() == 0) begin
          chk("unexpected_strobe", 32'(io.dn_wr), 0);
        end else begin
          e = q.pop_front();
          chk("dn_wr", 32'(io.dn_wr), 32'(e.wr));
          chk("dn_addr", 32'(io.dn_addr), 32'(e.addr));
          chk("dn_data", 32'(io.dn_data), 32'(e.data));
          chk("latency", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #1_500_000;
    miscompares++;
    $display("FAIL watchdog: time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    int bc;
    io.ioctl_download = 1'b0;
    io.ioctl_wr       = 1'b0;
    io.ioctl_addr     = '0;
    io.ioctl_dout     = '0;
    m_live = 1'b0;
    m_cnt  = 0;
    m_sum  = 0;
    m_ovf  = 1'b0;
    repeat (3) @(negedge clk_25);
    chk_reset_vals();
    reset = 1'b0;
    @(negedge clk_25);

    repeat (5) send_byte($urandom_range(0, 'h30FF),
                         8'($urandom));
    chk("idle_byte_count", 32'(byte_count), 0);
    chk("idle_checksum", 32'(checksum), 0);
    chk("idle_core_reset", 32'(core_reset), 1);

    start_dl();
    @(negedge clk_25);
    full_load(1'b0);
    finish_dl(1'b0);
    chk("prog_pulses", tot_r[0] - base_r[0], R0);
    chk("vec_pulses", tot_r[1] - base_r[1], R1);
    chk("prom_pulses", tot_r[2] - base_r[2], R2);

    bc = int'(byte_count);
    repeat (6) send_byte($urandom_range(0, 'h30FF),
                         8'($urandom));
    chk("run_byte_count", 32'(byte_count), bc);
    chk("run_checksum", 32'(checksum), m_sum);
    chk("run_core_reset", 32'(core_reset), 0);

    start_dl();
    @(negedge clk_25);
    for (int a = 0; a < R0; a++) send_byte(a, 8'($urandom));
    finish_dl(1'b0);

    start_dl();
    send_byte('h1FFF, 8'($urandom));
    send_byte('h2000, 8'($urandom));
    send_byte('h2FFF, 8'($urandom));
    send_byte('h3000, 8'($urandom));
    send_byte('h3100, 8'($urandom));
    finish_dl(1'b1);

    start_dl();
    @(negedge clk_25);
    full_load(1'b1);
    io.ioctl_download = 1'b0;
    m_live = 1'b0;
    repeat (500) @(negedge clk_25);
    chk("mid_hold_core_reset", 32'(core_reset), 1);
    chk("mid_hold_load_ok", 32'(load_ok), 0);
    start_dl();
    @(negedge clk_25);
    chk("restart_byte_count", 32'(byte_count), 0);
    chk("restart_checksum", 32'(checksum), 0);
    full_load(1'b1);
    finish_dl(1'b0);

    start_dl();
    @(negedge clk_25);
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk_25);
      send_byte($urandom_range(0, 'h3200), 8'($urandom));
    end
    finish_dl(1'b0);

    start_dl();
    @(negedge clk_25);
    for (int a = 0; a < 100; a++) send_byte(a, 8'($urandom));
    #2;
    reset = 1'b1;
    m_live = 1'b0;
    q.delete();
    #1;
    chk_reset_vals();
    @(negedge clk_25);
    reset = 1'b0;
    for (int a = 100; a < 120; a++) send_byte(a, 8'($urandom));
    chk("post_rst_byte_count", 32'(byte_count), 0);
    io.ioctl_download = 1'b0;
    repeat (HOLD + 40) @(negedge clk_25);
    chk("post_rst_core_reset", 32'(core_reset), 1);
    chk("post_rst_load_ok", 32'(load_ok), 0);
    chk("post_rst_load_err", 32'(load_err), 0);
    chk("post_rst_checksum", 32'(checksum), 0);

    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
